// File: rtl/hazard_pkg.sv
// Shared opcode constants, controller state encoding and RV32I source-usage decode
// for the ID-stage hazard controller.
package hazard_pkg;

  localparam int unsigned OPC_W = 7;

  localparam logic [OPC_W-1:0] OP_R     = 7'b0110011;
  localparam logic [OPC_W-1:0] OP_S     = 7'b0100011;
  localparam logic [OPC_W-1:0] OP_B     = 7'b1100011;
  localparam logic [OPC_W-1:0] OP_IALU  = 7'b0010011;
  localparam logic [OPC_W-1:0] OP_LOAD  = 7'b0000011;
  localparam logic [OPC_W-1:0] OP_JALR  = 7'b1100111;
  localparam logic [OPC_W-1:0] OP_LUI   = 7'b0110111;
  localparam logic [OPC_W-1:0] OP_AUIPC = 7'b0010111;
  localparam logic [OPC_W-1:0] OP_JAL   = 7'b1101111;

  typedef enum logic {
    RUN     = 1'b0,
    BR_WAIT = 1'b1
  } state_t;

  typedef struct packed {
    logic rs1;
    logic rs2;
  } src_use_t;

  // Which register sources an opcode actually reads.
  function automatic src_use_t src_use(input logic [OPC_W-1:0] opcode);
    src_use_t u;
    u = '0;
    case (opcode)
      OP_R, OP_S, OP_B: begin
        u.rs1 = 1'b1;
        u.rs2 = 1'b1;
      end
      OP_IALU, OP_LOAD, OP_JALR: u.rs1 = 1'b1;
      default: u = '0;
    endcase
    return u;
  endfunction

  // Control-transfer instructions that park the front end until EX resolves.
  function automatic logic is_branch(input logic [OPC_W-1:0] opcode);
    return (opcode == OP_B) || (opcode == OP_JAL) || (opcode == OP_JALR);
  endfunction

endpackage

// File: rtl/hazard_detect.sv
// Combinational RAW detector: compares the ID sources that are really read
// against the later-stage destinations, either all stages or load-use only.
module hazard_detect
  import hazard_pkg::*;
#(
  parameter int unsigned FORWARDING = 0,
  parameter int unsigned REG_W      = 5
) (
  input  logic             valid,
  input  logic [OPC_W-1:0] opcode,
  input  logic [REG_W-1:0] rs1,
  input  logic [REG_W-1:0] rs2,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             ex_reg_write,
  input  logic             ex_mem_read,
  input  logic [REG_W-1:0] mem_rd,
  input  logic             mem_reg_write,
  input  logic [REG_W-1:0] wb_rd,
  input  logic             wb_reg_write,
  output logic             data_hazard
);

  src_use_t use_c;
  logic     live_rs1;
  logic     live_rs2;
  logic     ex_hit;
  logic     mem_hit;
  logic     wb_hit;

  // x0 never carries a dependency, so zero sources are dropped up front.
  always_comb begin
    use_c    = src_use(opcode);
    live_rs1 = use_c.rs1 && (rs1 != '0);
    live_rs2 = use_c.rs2 && (rs2 != '0);
    ex_hit   = ex_reg_write  && ((live_rs1 && (rs1 == ex_rd))  || (live_rs2 && (rs2 == ex_rd)));
    mem_hit  = mem_reg_write && ((live_rs1 && (rs1 == mem_rd)) || (live_rs2 && (rs2 == mem_rd)));
    wb_hit   = wb_reg_write  && ((live_rs1 && (rs1 == wb_rd))  || (live_rs2 && (rs2 == wb_rd)));
    if (FORWARDING != 0) begin
      data_hazard = valid && ex_mem_read && ex_hit;
    end else begin
      data_hazard = valid && (ex_hit || mem_hit || wb_hit);
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// ID-stage hazard controller: RAW stall, branch wait until EX resolves,
// memory-busy freeze, and saturating stall/flush performance counters.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int unsigned FORWARDING = 0,
  parameter int unsigned REG_W      = 5,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             id_valid,
  input  logic [OPC_W-1:0] id_opcode,
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             ex_reg_write,
  input  logic             ex_mem_read,
  input  logic [REG_W-1:0] mem_rd,
  input  logic             mem_reg_write,
  input  logic [REG_W-1:0] wb_rd,
  input  logic             wb_reg_write,
  input  logic             br_resolve,
  input  logic             mem_busy,
  output logic             pc_load,
  output logic             if_id_load,
  output logic             if_id_flush,
  output logic             id_ex_bubble,
  output logic             pipe_hold,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  state_t state;
  state_t state_nxt;
  logic   data_hazard;
  logic   stall_inc;
  logic   flush_inc;

  hazard_detect #(
    .FORWARDING (FORWARDING),
    .REG_W      (REG_W)
  ) u_detect (
    .valid         (id_valid),
    .opcode        (id_opcode),
    .rs1           (id_rs1),
    .rs2           (id_rs2),
    .ex_rd         (ex_rd),
    .ex_reg_write  (ex_reg_write),
    .ex_mem_read   (ex_mem_read),
    .mem_rd        (mem_rd),
    .mem_reg_write (mem_reg_write),
    .wb_rd         (wb_rd),
    .wb_reg_write  (wb_reg_write),
    .data_hazard   (data_hazard)
  );

  // Priority decode: reset, memory hold, branch wait, data stall, branch accept, run.
  always_comb begin
    pc_load      = 1'b0;
    if_id_load   = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_bubble = 1'b0;
    pipe_hold    = 1'b0;
    state_nxt    = state;
    stall_inc    = 1'b0;
    flush_inc    = 1'b0;
    if (!reset) begin
      if_id_flush  = 1'b1;
      id_ex_bubble = 1'b1;
      state_nxt    = RUN;
    end else if (mem_busy) begin
      pipe_hold = 1'b1;
    end else if (state == BR_WAIT) begin
      if_id_flush = 1'b1;
      flush_inc   = 1'b1;
      if (br_resolve) begin
        pc_load   = 1'b1;
        state_nxt = RUN;
      end
    end else if (data_hazard) begin
      id_ex_bubble = 1'b1;
      stall_inc    = 1'b1;
    end else if (id_valid && is_branch(id_opcode)) begin
      if_id_flush = 1'b1;
      state_nxt   = BR_WAIT;
    end else begin
      pc_load    = 1'b1;
      if_id_load = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= RUN;
    end else begin
      state <= state_nxt;
    end
  end

  // Counters stick at all-ones rather than wrapping.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall_inc && (stall_cnt != '1)) begin
        stall_cnt <= stall_cnt + CNT_W'(1);
      end
      if (flush_inc && (flush_cnt != '1)) begin
        flush_cnt <= flush_cnt + CNT_W'(1);
      end
    end
  end

endmodule
